// File: rtl/vjtag_dr_responder.sv
// vjtag_dr_responder: virtual JTAG data-register responder driving a tck-clocked image RAM
module vjtag_dr_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              tck,
    input  logic              reset_n,
    input  logic [1:0]        ir_in,
    input  logic              tdi,
    output logic              tdo,
    output logic [1:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   wr_count
);
    localparam logic [1:0] IR_BYPASS = 2'b00;
    localparam logic [1:0] IR_ADDR   = 2'b01;
    localparam logic [1:0] IR_WRITE  = 2'b10;
    localparam logic [1:0] IR_READ   = 2'b11;

    logic              bypass;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic [ADDR_W-1:0] ptr;
    logic              wrap_flag;
    logic              write_pending;
    logic              rd_inc;
    logic              upd_addr;
    logic              upd_write;
    logic              step;

    assign upd_addr  = virtual_state_udr && ir_in == IR_ADDR;
    assign upd_write = virtual_state_udr && ir_in == IR_WRITE;
    assign step      = mem_we || rd_inc;
    assign mem_addr  = ptr;
    assign ir_out    = {wrap_flag, write_pending};
    assign tdo       = (ir_in == IR_BYPASS) ? bypass : (ir_in == IR_ADDR) ? addr_sr[0] : data_sr[0];

    // Capture and LSB-first shift of the selected register; update strobe takes priority
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            bypass  <= 1'b0;
            addr_sr <= '0;
            data_sr <= '0;
        end else if (!virtual_state_udr) begin
            if (virtual_state_sdr) begin
                if (ir_in == IR_BYPASS) bypass <= tdi;
                else if (ir_in == IR_ADDR) addr_sr <= {tdi, addr_sr[ADDR_W-1:1]};
                else data_sr <= {tdi, data_sr[DATA_W-1:1]};
            end else if (virtual_state_cdr) begin
                if (ir_in == IR_BYPASS) bypass <= 1'b0;
                else if (ir_in == IR_ADDR) addr_sr <= ptr;
                else data_sr <= (ir_in == IR_READ) ? mem_rdata : '0;
            end
        end
    end

    // Pointer, write strobe pipeline, wrap flag and saturating write count
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= '0;
            wrap_flag     <= 1'b0;
            write_pending <= 1'b0;
            rd_inc        <= 1'b0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            wr_count      <= '0;
        end else begin
            mem_we <= upd_write;
            rd_inc <= virtual_state_udr && ir_in == IR_READ;
            if (upd_write) begin
                mem_wdata     <= data_sr;
                write_pending <= 1'b1;
            end else if (mem_we) begin
                write_pending <= 1'b0;
            end
            if (upd_addr) begin
                ptr       <= addr_sr;
                wrap_flag <= 1'b0;
                wr_count  <= '0;
            end else if (step) begin
                ptr <= ptr + ADDR_W'(1);
                if (&ptr) wrap_flag <= 1'b1;
                if (mem_we && !wr_count[ADDR_W]) wr_count <= wr_count + (ADDR_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_vjtag_dr_responder.sv
// tb_vjtag_dr_responder: directed self-checking bench with a tck-clocked RAM model
module tb_vjtag_dr_responder;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    logic              tck = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        ir_in = 2'b00;
    logic              tdi = 1'b0;
    logic              cdr = 1'b0;
    logic              sdr = 1'b0;
    logic              udr = 1'b0;
    logic              tdo;
    logic [1:0]        ir_out;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   wr_count;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    int                we_cnt = 0;
    logic [ADDR_W-1:0] last_waddr;
    logic [DATA_W-1:0] last_wdata;
    int                checks = 0;
    int                errors = 0;
    logic [31:0]       d;

    vjtag_dr_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .tck(tck), .reset_n(reset_n), .ir_in(ir_in), .tdi(tdi), .tdo(tdo), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .wr_count(wr_count)
    );

    always #5 tck = ~tck;

    // Synchronous single-port RAM with one-cycle read latency, logging every write
    always @(posedge tck) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_waddr    <= mem_addr;
            last_wdata    <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic s, input logic u);
        @(negedge tck);
        cdr = c; sdr = s; udr = u;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic dr(input logic [1:0] ir, input int n, input logic [31:0] din, input logic upd,
                      output logic [31:0] dout);
        dout = '0;
        @(negedge tck);
        ir_in = ir; cdr = 1'b1; sdr = 1'b0; udr = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            @(negedge tck);
            cdr = 1'b0; sdr = 1'b1; udr = 1'b0; tdi = din[i];
            #1;
            dout[i] = tdo;
        end
        cyc(1'b0, 1'b0, 1'b0);
        if (upd) cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        idle(3);
        check("rst_tdo", 32'(tdo), 0);
        check("rst_ir_out", 32'(ir_out), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        reset_n = 1'b1;
        idle(2);

        dr(2'b00, 4, 32'hD, 1'b1, d);
        check("bypass_tdo", d, 32'hA);
        idle(2);
        check("bypass_no_we", we_cnt, 0);

        dr(2'b01, 16, 32'h0010, 1'b1, d);
        idle(2);
        check("addr_mem_addr", 32'(mem_addr), 32'h10);
        check("addr_wr_count", 32'(wr_count), 0);
        check("addr_ir_out", 32'(ir_out), 0);

        dr(2'b10, 8, 32'hA5, 1'b1, d);
        cyc(1'b0, 1'b0, 1'b0);
        check("w1_we_high", 32'(mem_we), 1);
        check("w1_addr", 32'(mem_addr), 32'h10);
        check("w1_wdata", 32'(mem_wdata), 32'hA5);
        check("w1_pending", 32'(ir_out), 32'b01);
        cyc(1'b0, 1'b0, 1'b0);
        check("w1_we_low", 32'(mem_we), 0);
        check("w1_ptr_inc", 32'(mem_addr), 32'h11);
        check("w1_wr_count", 32'(wr_count), 1);
        check("w1_pending_clr", 32'(ir_out), 0);
        idle(1);

        dr(2'b10, 8, 32'h3C, 1'b1, d);
        idle(2);
        check("w2_mem_addr", 32'(mem_addr), 32'h12);
        check("w2_wr_count", 32'(wr_count), 2);
        check("w2_we_cnt", we_cnt, 2);
        check("w2_waddr", 32'(last_waddr), 32'h11);
        check("w2_wdata", 32'(last_wdata), 32'h3C);

        dr(2'b01, 16, 32'h0010, 1'b1, d);
        check("addr_capture_ptr", d, 32'h12);
        idle(2);
        check("addr_clr_count", 32'(wr_count), 0);
        dr(2'b11, 8, 32'h0, 1'b1, d);
        check("read1_tdo", d, 32'hA5);
        idle(2);
        dr(2'b11, 8, 32'h0, 1'b1, d);
        check("read2_tdo", d, 32'h3C);
        idle(2);
        check("read_ptr_end", 32'(mem_addr), 32'h12);
        check("read_no_we", we_cnt, 2);

        dr(2'b01, 16, 32'hFFFF, 1'b1, d);
        idle(2);
        dr(2'b10, 8, 32'h77, 1'b1, d);
        cyc(1'b0, 1'b0, 1'b0);
        check("wrap_we", 32'(mem_we), 1);
        check("wrap_waddr", 32'(mem_addr), 32'hFFFF);
        cyc(1'b0, 1'b0, 1'b0);
        check("wrap_ptr_zero", 32'(mem_addr), 0);
        check("wrap_flag_set", 32'(ir_out), 32'b10);
        check("wrap_wr_count", 32'(wr_count), 1);
        idle(1);
        dr(2'b01, 16, 32'h0005, 1'b1, d);
        check("wrap_capture_ptr", d, 0);
        idle(2);
        check("wrap_flag_clr", 32'(ir_out), 0);
        check("wrap_new_addr", 32'(mem_addr), 32'h5);
        check("wrap_count_clr", 32'(wr_count), 0);

        dr(2'b01, 16, 32'h0020, 1'b1, d);
        idle(2);
        dr(2'b10, 8, 32'h55, 1'b1, d);
        @(negedge tck);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 0);
        check("mid_rst_ir_out", 32'(ir_out), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_wdata", 32'(mem_wdata), 0);
        check("mid_rst_count", 32'(wr_count), 0);
        check("mid_rst_tdo", 32'(tdo), 0);
        idle(2);
        check("mid_rst_no_write", we_cnt, 3);
        reset_n = 1'b1;
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
